// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - producer/write-port bundle for the write-back arbiter
//
// Purpose: groups the per-source push channels and the register-file write
//          port of wb_arbiter into one interface.
// Signals:
//   s_valid/s_ready  per-source handshake (N_SRC bits)
//   s_addr/s_data    packed per-source destination address / result data,
//                    source i at [i*L +: L]
//   ard/drd          register-file write address/data (ard == 0 means idle)
//   wb_valid         write strobe, high whenever ard != 0
//   wb_src           index of the source currently on ard/drd
//   busy             any queued entry or a write in flight
// Modports: master = execution-unit side, slave = arbiter side.

`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

interface wb_arbiter_if #(
   parameter int N_SRC = 3
) ();
   localparam int LA = `LEN_PREG_ADDR;
   localparam int LW = `LEN_WORD;
   localparam int SW = $clog2(N_SRC);

   logic [N_SRC-1:0]    s_valid;
   logic [N_SRC-1:0]    s_ready;
   logic [N_SRC*LA-1:0] s_addr;
   logic [N_SRC*LW-1:0] s_data;
   logic [LA-1:0]       ard;
   logic [LW-1:0]       drd;
   logic                wb_valid;
   logic [SW-1:0]       wb_src;
   logic                busy;

   modport master (
      output s_valid, s_addr, s_data,
      input  s_ready, ard, drd, wb_valid, wb_src, busy
   );

   modport slave (
      input  s_valid, s_addr, s_data,
      output s_ready, ard, drd, wb_valid, wb_src, busy
   );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - multi-source write-back arbiter onto the register-file write port
//
// Purpose: each execution unit pushes (preg address, data) pairs into its own
//          DEPTH-entry FIFO; every cycle at most one non-empty FIFO is granted
//          and its head is registered onto ard/drd.
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   wb_arbiter_if.slave (s_valid/s_ready/s_addr/s_data in,
//         ard/drd/wb_valid/wb_src/busy out)
// Build option: WB_ARB_RR_EN selects round-robin grant; otherwise fixed
//               priority with the lowest source index winning.

`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module wb_arbiter #(
   parameter int N_SRC = 3,
   parameter int DEPTH = 2
) (
   input logic          clk,
   input logic          rstn,
   wb_arbiter_if.slave  bus
);
   localparam int LA = `LEN_PREG_ADDR;
   localparam int LW = `LEN_WORD;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(N_SRC);

   logic [LA-1:0] r_mem_addr [N_SRC][DEPTH];
   logic [LW-1:0] r_mem_data [N_SRC][DEPTH];
   logic [PW-1:0] r_wptr  [N_SRC];
   logic [PW-1:0] r_rptr  [N_SRC];
   logic [CW-1:0] r_count [N_SRC];

   logic [LA-1:0] r_ard;
   logic [LW-1:0] r_drd;
   logic          r_wb_valid;
   logic [SW-1:0] r_wb_src;

   logic [N_SRC-1:0] w_ready;
   logic [N_SRC-1:0] w_push;
   logic [N_SRC-1:0] w_req;
   logic [N_SRC-1:0] w_pop;
   logic             w_gnt;
   logic [SW-1:0]    w_gnt_idx;

   // Ready comes only from the registered count, so there is no path from
   // s_valid or the grant. Address-0 entries are accepted but never stored.
   always_comb begin
      w_ready = '0;
      w_push  = '0;
      w_req   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_ready[i] = rstn && (r_count[i] < CW'(DEPTH));
         w_push[i]  = bus.s_valid[i] && w_ready[i] && (bus.s_addr[i*LA +: LA] != '0);
         w_req[i]   = (r_count[i] != '0);
      end
   end

`ifdef WB_ARB_RR_EN
   logic [SW-1:0] r_rr_ptr;
   int            w_idx;

   // Search starts one past the last granted source.
   always_comb begin
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
      w_idx     = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         w_idx = (int'(r_rr_ptr) + k) % N_SRC;
         if (!w_gnt && w_req[SW'(w_idx)]) begin
            w_gnt     = 1'b1;
            w_gnt_idx = SW'(w_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rr_ptr <= SW'(N_SRC - 1);
      end else if (w_gnt) begin
         r_rr_ptr <= w_gnt_idx;
      end
   end
`else
   // Scan from the top so the lowest requesting index is the last writer.
   always_comb begin
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_gnt     = 1'b1;
            w_gnt_idx = SW'(i);
         end
      end
   end
`endif

   always_comb begin
      w_pop = '0;
      if (w_gnt) begin
         w_pop[w_gnt_idx] = 1'b1;
      end
   end

   // Storage carries no reset; validity is tracked by the counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (w_push[i]) begin
            r_mem_addr[i][r_wptr[i]] <= bus.s_addr[i*LA +: LA];
            r_mem_data[i][r_wptr[i]] <= bus.s_data[i*LW +: LW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < N_SRC; i++) begin
            r_wptr[i]  <= '0;
            r_rptr[i]  <= '0;
            r_count[i] <= '0;
         end
         r_ard      <= '0;
         r_drd      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_src   <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (w_push[i]) begin
               r_wptr[i] <= r_wptr[i] + 1'b1;
            end
            if (w_pop[i]) begin
               r_rptr[i] <= r_rptr[i] + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
         end
         if (w_gnt) begin
            r_ard      <= r_mem_addr[w_gnt_idx][r_rptr[w_gnt_idx]];
            r_drd      <= r_mem_data[w_gnt_idx][r_rptr[w_gnt_idx]];
            r_wb_valid <= 1'b1;
            r_wb_src   <= w_gnt_idx;
         end else begin
            r_ard      <= '0;
            r_drd      <= '0;
            r_wb_valid <= 1'b0;
         end
      end
   end

   assign bus.s_ready  = w_ready;
   assign bus.ard      = r_ard;
   assign bus.drd      = r_drd;
   assign bus.wb_valid = r_wb_valid;
   assign bus.wb_src   = r_wb_src;
   assign bus.busy     = (|w_req) | r_wb_valid;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter

`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module tb_wb_arbiter;
   localparam int N  = 3;
   localparam int LA = `LEN_PREG_ADDR;
   localparam int LW = `LEN_WORD;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   wb_arbiter_if #(.N_SRC(N)) bus ();

   wb_arbiter #(.N_SRC(N), .DEPTH(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [LA-1:0] a, input logic [LW-1:0] d);
      bus.s_valid[i]         = v;
      bus.s_addr[i*LA +: LA] = a;
      bus.s_data[i*LW +: LW] = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, '0);
   endtask

   task automatic test_reset();
      clear_all();
      rstn = 1'b0;
      tick();
      tick();
      n_tests++; if (bus.ard !== '0) begin n_fail++; $display("FAIL reset_ard actual=%0h expected=0", bus.ard); end
      n_tests++; if (bus.drd !== '0) begin n_fail++; $display("FAIL reset_drd actual=%0h expected=0", bus.drd); end
      n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid actual=%0b expected=0", bus.wb_valid); end
      n_tests++; if (bus.wb_src !== '0) begin n_fail++; $display("FAIL reset_wb_src actual=%0d expected=0", bus.wb_src); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%0b expected=0", bus.busy); end
      n_tests++; if (bus.s_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready_low actual=%b expected=000", bus.s_ready); end
      rstn = 1'b1;
      #1;
      n_tests++; if (bus.s_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready_high actual=%b expected=111", bus.s_ready); end
      tick();
   endtask

   task automatic test_single();
      set_src(0, 1'b1, LA'(5), 32'hDEADBEEF);
      tick();
      clear_all();
      n_tests++; if (bus.ard !== '0) begin n_fail++; $display("FAIL single_latency_ard actual=%0h expected=0", bus.ard); end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued actual=%0b expected=1", bus.busy); end
      tick();
      n_tests++; if (bus.ard !== LA'(5)) begin n_fail++; $display("FAIL single_ard actual=%0h expected=5", bus.ard); end
      n_tests++; if (bus.drd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_drd actual=%0h expected=deadbeef", bus.drd); end
      n_tests++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid actual=%0b expected=1", bus.wb_valid); end
      n_tests++; if (bus.wb_src !== 2'd0) begin n_fail++; $display("FAIL single_wb_src actual=%0d expected=0", bus.wb_src); end
      tick();
      n_tests++; if (bus.ard !== '0) begin n_fail++; $display("FAIL single_idle_ard actual=%0h expected=0", bus.ard); end
      n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_wb_valid actual=%0b expected=0", bus.wb_valid); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy actual=%0b expected=0", bus.busy); end
   endtask

   task automatic test_zero_addr();
      set_src(1, 1'b1, '0, 32'h1234);
      n_tests++; if (bus.s_ready[1] !== 1'b1) begin n_fail++; $display("FAIL zero_ready actual=%0b expected=1", bus.s_ready[1]); end
      tick();
      clear_all();
      for (int c = 0; c < 3; c++) begin
         n_tests++; if (bus.ard !== '0) begin n_fail++; $display("FAIL zero_ard cyc=%0d actual=%0h expected=0", c, bus.ard); end
         n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy cyc=%0d actual=%0b expected=0", c, bus.busy); end
         tick();
      end
   endtask

   task automatic test_contention();
`ifdef WB_ARB_RR_EN
      int exp_ard [12] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 0};
`else
      int exp_ard [12] = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 0};
`endif
      for (int i = 0; i < N; i++) set_src(i, 1'b1, LA'(i + 1), 32'hA0000000 + LW'(i));
      for (int e = 1; e <= 12; e++) begin
         if (e == 7) clear_all();
         tick();
         n_tests++;
         if (bus.ard !== LA'(exp_ard[e-1])) begin
            n_fail++; $display("FAIL contention_ard edge=%0d actual=%0d expected=%0d", e, bus.ard, exp_ard[e-1]);
         end
         if (exp_ard[e-1] != 0) begin
            n_tests++;
            if (bus.wb_src !== 2'(exp_ard[e-1] - 1)) begin
               n_fail++; $display("FAIL contention_src edge=%0d actual=%0d expected=%0d", e, bus.wb_src, exp_ard[e-1] - 1);
            end
            n_tests++;
            if (bus.drd !== 32'hA0000000 + LW'(exp_ard[e-1] - 1)) begin
               n_fail++; $display("FAIL contention_drd edge=%0d actual=%0h expected=%0h", e, bus.drd, 32'hA0000000 + LW'(exp_ard[e-1] - 1));
            end
         end
      end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL contention_drained_busy actual=%0b expected=0", bus.busy); end
   endtask

   task automatic test_back_to_back();
`ifdef WB_ARB_RR_EN
      int exp_seq [$] = '{1, 10, 1, 11, 1, 12, 1};
`else
      int exp_seq [$] = '{1, 1, 1, 1, 1, 10, 11, 12};
`endif
      int   seq [$];
      int   b2_addr [3] = '{10, 11, 12};
      int   sent2 = 0;
      logic acc2;
      for (int c = 0; c < 16; c++) begin
         set_src(0, c < 5, LA'(1), 32'hC0);
         if (sent2 < 3) set_src(2, 1'b1, LA'(b2_addr[sent2]), 32'hB0 + LW'(sent2));
         else           set_src(2, 1'b0, '0, '0);
         acc2 = bus.s_valid[2] && bus.s_ready[2];
         tick();
         if (acc2) sent2++;
         if (c == 1) begin
            n_tests++; if (sent2 !== 2) begin n_fail++; $display("FAIL b2b_accepts actual=%0d expected=2", sent2); end
            n_tests++; if (bus.s_ready[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready actual=%0b expected=0", bus.s_ready[2]); end
         end
         if (bus.wb_valid === 1'b1) begin
            seq.push_back(int'(bus.ard));
            n_tests++;
            if (bus.ard == LA'(1)) begin
               if (bus.drd !== 32'hC0) begin n_fail++; $display("FAIL b2b_drd src0 actual=%0h expected=c0", bus.drd); end
            end else if (bus.drd !== 32'hB0 + LW'(int'(bus.ard) - 10)) begin
               n_fail++; $display("FAIL b2b_drd addr=%0d actual=%0h expected=%0h", bus.ard, bus.drd, 32'hB0 + LW'(int'(bus.ard) - 10));
            end
         end
      end
      clear_all();
      n_tests++; if (seq.size() !== exp_seq.size()) begin n_fail++; $display("FAIL b2b_write_count actual=%0d expected=%0d", seq.size(), exp_seq.size()); end
      for (int k = 0; k < exp_seq.size(); k++) begin
         n_tests++;
         if (k >= seq.size()) begin
            n_fail++; $display("FAIL b2b_order idx=%0d actual=missing expected=%0d", k, exp_seq[k]);
         end else if (seq[k] !== exp_seq[k]) begin
            n_fail++; $display("FAIL b2b_order idx=%0d actual=%0d expected=%0d", k, seq[k], exp_seq[k]);
         end
      end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drained_busy actual=%0b expected=0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int nonzero = 0;
      set_src(0, 1'b1, LA'(7), 32'h7);
      set_src(1, 1'b1, LA'(8), 32'h8);
      tick();
      clear_all();
      rstn = 1'b0;
      #1;
      n_tests++; if (bus.s_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_ready_low actual=%b expected=000", bus.s_ready); end
      tick();
      rstn = 1'b1;
      #1;
      n_tests++; if (bus.ard !== '0) begin n_fail++; $display("FAIL midrst_ard actual=%0h expected=0", bus.ard); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy actual=%0b expected=0", bus.busy); end
      n_tests++; if (bus.wb_src !== '0) begin n_fail++; $display("FAIL midrst_wb_src actual=%0d expected=0", bus.wb_src); end
      n_tests++; if (bus.s_ready !== 3'b111) begin n_fail++; $display("FAIL midrst_ready_high actual=%b expected=111", bus.s_ready); end
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.ard !== '0 || bus.busy !== 1'b0) nonzero++;
      end
      n_tests++; if (nonzero !== 0) begin n_fail++; $display("FAIL midrst_dropped cycles_with_write=%0d expected=0", nonzero); end
   endtask

   initial begin
      clear_all();
      test_reset();
      test_single();
      test_zero_addr();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
